// File: rtl/sat_add_arbiter.sv
// sat_add_arbiter: round-robin arbiter sharing one signed saturating adder among N requesters
module sat_add_arbiter #(
    parameter int N   = 4,
    parameter int W   = 4,
    parameter int CW  = 8,
    localparam int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDW-1:0]   out_id,
    output logic [W-1:0]     out_sum,
    output logic             out_sat,
    output logic [CW-1:0]    sat_count
);
    logic [IDW-1:0] ptr, g, idx;
    logic           found, can_accept, xfer, ovf;
    logic [W-1:0]   a, b, r, sum;

    assign can_accept = !out_valid || out_ready;

    // first valid requester at or after ptr, wrapping around
    always_comb begin
        g = '0;
        idx = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                g = idx;
            end
        end
    end

    assign req_ready = (found && can_accept && !rst) ? (N'(1) << g) : '0;
    assign xfer = |req_ready;

    // select the winner's operands
    always_comb begin
        a = '0;
        b = '0;
        for (int i = 0; i < N; i++) begin
            if (g == IDW'(i)) begin
                a = req_a[i*W +: W];
                b = req_b[i*W +: W];
            end
        end
    end

    assign r   = a + b;
    assign ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    assign sum = ovf ? (a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : r;

    // output stage, rotating pointer and saturating event counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
            sat_count <= '0;
        end else begin
            if (xfer) begin
                ptr       <= (g == IDW'(N-1)) ? '0 : g + 1'b1;
                out_valid <= 1'b1;
                out_id    <= g;
                out_sum   <= sum;
                out_sat   <= ovf;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer && ovf && !(&sat_count))
                sat_count <= sat_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_sat_add_arbiter.sv
// tb_sat_add_arbiter: directed vectors with a result scoreboard for sat_add_arbiter
module tb_sat_add_arbiter;
    localparam int N = 4, W = 4, CW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic           out_valid, out_ready;
    logic [1:0]     out_id;
    logic [W-1:0]   out_sum;
    logic           out_sat;
    logic [CW-1:0]  sat_count;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] sum;
        logic         sat;
    } res_t;

    res_t exp_q[$];
    int checks = 0;
    int fails = 0;

    sat_add_arbiter #(.N(N), .W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_sum(out_sum), .out_sat(out_sat),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // inputs are already driven; check the same-cycle grant and queue its result
    task automatic expect_grant(input int g, input logic [W-1:0] s, input logic sat);
        res_t e;
        #1;
        chk("req_ready", 32'(req_ready), 32'(1) << g);
        e.id = 2'(g);
        e.sum = s;
        e.sat = sat;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_id", 32'(out_id), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_out_sat", 32'(out_sat), 0);
        chk("rst_sat_count", 32'(sat_count), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
    endtask

    // monitor: every accepted result must match the oldest expectation
    always @(negedge clk) begin
        res_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_result: got id %0d sum %0h, none expected", out_id, out_sum);
            end else begin
                e = exp_q.pop_front();
                chk("out_id", 32'(out_id), 32'(e.id));
                chk("out_sum", 32'(out_sum), 32'(e.sum));
                chk("out_sat", 32'(out_sat), 32'(e.sat));
            end
        end
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        out_ready = 1'b0;
        repeat (3) step();
        chk_reset_state();

        // single requester: 3 + -5 = -2
        rst = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b0001;
        set_req(0, 4'd3, 4'hB);
        expect_grant(0, 4'hE, 1'b0);
        step();
        req_valid = '0;
        #1;
        chk("single_out_valid", 32'(out_valid), 1);
        chk("single_sat_count", 32'(sat_count), 0);

        // saturation on requester 2
        req_valid = 4'b0100;
        set_req(2, 4'd4, 4'd7);
        expect_grant(2, 4'h7, 1'b1);
        step();
        set_req(2, 4'hC, 4'h9);
        expect_grant(2, 4'h8, 1'b1);
        step();
        chk("sat_count_2", 32'(sat_count), 2);
        set_req(2, 4'd4, 4'hC);
        expect_grant(2, 4'h0, 1'b0);
        step();
        chk("sat_count_hold", 32'(sat_count), 2);

        // bring ptr back to 0 via requester 3
        req_valid = 4'b1000;
        set_req(3, 4'd1, 4'd1);
        expect_grant(3, 4'd2, 1'b0);
        step();

        // round robin with everyone valid: operands give sum i+1
        for (int i = 0; i < N; i++) set_req(i, 4'(i), 4'd1);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            expect_grant(c % N, 4'((c % N) + 1), 1'b0);
            step();
        end
        req_valid = 4'b1010;
        expect_grant(1, 4'd2, 1'b0);
        step();
        expect_grant(3, 4'd4, 1'b0);
        step();
        expect_grant(1, 4'd2, 1'b0);
        step();

        // backpressure: last result (id 1, sum 2) must be held and nothing granted
        out_ready = 1'b0;
        req_valid = 4'b0010;
        set_req(1, 4'd5, 4'h9);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_id", 32'(out_id), 1);
            chk("bp_out_sum", 32'(out_sum), 2);
            chk("bp_out_sat", 32'(out_sat), 0);
            step();
        end
        out_ready = 1'b1;
        expect_grant(1, 4'hE, 1'b0);
        step();
        req_valid = '0;
        #1;
        chk("bp_release_valid", 32'(out_valid), 1);

        // counter saturation: 2 + 260 overflows clamp at 255
        req_valid = 4'b0001;
        set_req(0, 4'd7, 4'd1);
        for (int c = 0; c < 260; c++) begin
            expect_grant(0, 4'h7, 1'b1);
            step();
        end
        req_valid = '0;
        #1;
        chk("sat_count_max", 32'(sat_count), 255);

        // reset while a result is pending and all requesters are valid
        out_ready = 1'b0;
        req_valid = 4'b1111;
        set_req(0, 4'd0, 4'd1);
        step();
        rst = 1'b1;
        #1;
        chk("rst_blocks_grant", 32'(req_ready), 0);
        step();
        exp_q.delete();
        chk_reset_state();
        rst = 1'b0;
        out_ready = 1'b1;
        expect_grant(0, 4'd1, 1'b0);
        step();
        req_valid = '0;

        // bounded drain of the scoreboard
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
